// File: rtl/lcd_text_scheduler.sv
// rtl/lcd_text_scheduler.sv - 2x16 LCD shadow buffer with init sequencing and dirty-line refresh
module lcd_text_scheduler #(
    parameter int unsigned CMD_WAIT   = 2000,
    parameter int unsigned CLEAR_WAIT = 100000,
    parameter int unsigned LINE_LEN   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       buf_we,
    input  logic [4:0] buf_addr,
    input  logic [7:0] buf_wdata,
    input  logic       refresh,
    output logic       lcd_valid,
    output logic       lcd_rs,
    output logic [7:0] lcd_byte,
    input  logic       lcd_ready,
    output logic       init_done,
    output logic       busy
);

    localparam logic [31:0] CMD_LIM   = 32'(CMD_WAIT - 1);
    localparam logic [31:0] CLEAR_LIM = 32'(CLEAR_WAIT - 1);
    localparam logic [3:0]  COL_LAST  = 4'(LINE_LEN - 1);

    typedef enum logic [2:0] {
        S_INIT_CMD,
        S_INIT_WAIT,
        S_IDLE,
        S_SET_ADDR,
        S_SEND_CHAR
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_idx;
    logic [31:0] r_wait;
    logic [1:0]  r_dirty;
    logic        r_rr_last;
    logic        r_line;
    logic [3:0]  r_col;
    logic [7:0]  r_buf [32];
    logic        r_lcd_valid;
    logic        r_lcd_rs;
    logic [7:0]  r_lcd_byte;
    logic        r_init_done;

    logic        w_accept;
    logic        w_wait_last;
    logic        w_sel_line;
    logic        w_start_line;
    logic        w_offer;
    logic        w_offer_rs;
    logic [7:0]  w_offer_byte;
    logic [7:0]  w_init_cmd;
    logic [1:0]  w_dirty_set;
    logic [1:0]  w_dirty_clr;

    assign w_accept     = r_lcd_valid && lcd_ready;
    assign w_wait_last  = (r_wait == ((r_idx == 2'd3) ? CLEAR_LIM : CMD_LIM));
    assign w_sel_line   = (r_dirty == 2'b11) ? ~r_rr_last : r_dirty[1];
    assign w_start_line = (r_state == S_IDLE) && (r_dirty != 2'b00);

    // Set beats clear: a write or refresh landing on the line being picked keeps it dirty.
    assign w_dirty_set  = (refresh ? 2'b11 : 2'b00)
                        | (buf_we ? (buf_addr[4] ? 2'b10 : 2'b01) : 2'b00);
    assign w_dirty_clr  = w_start_line ? (w_sel_line ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        w_init_cmd = 8'h28;
        case (r_idx)
            2'd0: w_init_cmd = 8'h28;
            2'd1: w_init_cmd = 8'h0C;
            2'd2: w_init_cmd = 8'h06;
            2'd3: w_init_cmd = 8'h01;
            default: w_init_cmd = 8'h28;
        endcase
    end

    always_comb begin
        w_next       = r_state;
        w_offer      = 1'b0;
        w_offer_rs   = 1'b0;
        w_offer_byte = 8'h00;
        case (r_state)
            S_INIT_CMD: begin
                w_offer      = !r_lcd_valid;
                w_offer_byte = w_init_cmd;
                if (w_accept) w_next = S_INIT_WAIT;
            end
            S_INIT_WAIT: begin
                if (w_wait_last) w_next = (r_idx == 2'd3) ? S_IDLE : S_INIT_CMD;
            end
            S_IDLE: begin
                if (r_dirty != 2'b00) w_next = S_SET_ADDR;
            end
            S_SET_ADDR: begin
                w_offer      = !r_lcd_valid;
                w_offer_byte = r_line ? 8'hC0 : 8'h80;
                if (w_accept) w_next = S_SEND_CHAR;
            end
            S_SEND_CHAR: begin
                w_offer      = !r_lcd_valid;
                w_offer_rs   = 1'b1;
                w_offer_byte = r_buf[{r_line, r_col}];
                if (w_accept && (r_col == COL_LAST)) w_next = S_IDLE;
            end
            default: w_next = S_INIT_CMD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_INIT_CMD;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lcd_valid <= 1'b0;
            r_lcd_rs    <= 1'b0;
            r_lcd_byte  <= 8'h00;
            r_init_done <= 1'b0;
            r_idx       <= 2'd0;
            r_wait      <= 32'd0;
            r_dirty     <= 2'b11;
            r_rr_last   <= 1'b1;
            r_line      <= 1'b0;
            r_col       <= 4'd0;
            for (int i = 0; i < 32; i++) r_buf[i] <= 8'h20;
        end else begin
            // Valid is registered and drops for a cycle after every accept.
            if (w_accept) begin
                r_lcd_valid <= 1'b0;
            end else if (w_offer) begin
                r_lcd_valid <= 1'b1;
                r_lcd_rs    <= w_offer_rs;
                r_lcd_byte  <= w_offer_byte;
            end

            if (r_state == S_INIT_CMD)       r_wait <= 32'd0;
            else if (r_state == S_INIT_WAIT) r_wait <= r_wait + 32'd1;

            if ((r_state == S_INIT_WAIT) && w_wait_last) begin
                r_idx <= r_idx + 2'd1;
                if (r_idx == 2'd3) r_init_done <= 1'b1;
            end

            if (w_start_line) begin
                r_line    <= w_sel_line;
                r_rr_last <= w_sel_line;
            end

            if ((r_state == S_SET_ADDR) && w_accept)       r_col <= 4'd0;
            else if ((r_state == S_SEND_CHAR) && w_accept) r_col <= r_col + 4'd1;

            r_dirty <= (r_dirty & ~w_dirty_clr) | w_dirty_set;

            if (buf_we) r_buf[buf_addr] <= buf_wdata;
        end
    end

    assign lcd_valid = r_lcd_valid;
    assign lcd_rs    = r_lcd_rs;
    assign lcd_byte  = r_lcd_byte;
    assign init_done = r_init_done;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_lcd_text_scheduler.sv
// tb/tb_lcd_text_scheduler.sv - directed self-checking bench for lcd_text_scheduler
module tb_lcd_text_scheduler;

    localparam int CMD_WAIT   = 20;
    localparam int CLEAR_WAIT = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic       buf_we;
    logic [4:0] buf_addr;
    logic [7:0] buf_wdata;
    logic       refresh;
    logic       lcd_valid;
    logic       lcd_rs;
    logic [7:0] lcd_byte;
    logic       lcd_ready;
    logic       init_done;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] tb_buf [32];
    logic       x_rs;
    logic [7:0] x_b;
    int         x_gap;

    lcd_text_scheduler #(
        .CMD_WAIT  (CMD_WAIT),
        .CLEAR_WAIT(CLEAR_WAIT),
        .LINE_LEN  (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .buf_we   (buf_we),
        .buf_addr (buf_addr),
        .buf_wdata(buf_wdata),
        .refresh  (refresh),
        .lcd_valid(lcd_valid),
        .lcd_rs   (lcd_rs),
        .lcd_byte (lcd_byte),
        .lcd_ready(lcd_ready),
        .init_done(init_done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge after the accepting posedge. Timeout yields x values.
    task automatic get_xfer(output logic rs, output logic [7:0] b, output int gap);
        bit got;
        got = 1'b0;
        gap = 0;
        rs  = 1'bx;
        b   = 8'hxx;
        while (!got && gap < 1000) begin
            if (lcd_valid && lcd_ready) begin
                rs  = lcd_rs;
                b   = lcd_byte;
                got = 1'b1;
            end else begin
                gap++;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_write(input logic [4:0] a, input logic [7:0] d);
        buf_we    = 1'b1;
        buf_addr  = a;
        buf_wdata = d;
        tb_buf[a] = d;
        @(negedge clk);
        buf_we    = 1'b0;
    endtask

    task automatic test_reset;
        rst       = 1'b0;
        lcd_ready = 1'b1;
        buf_we    = 1'b0;
        buf_addr  = 5'd0;
        buf_wdata = 8'd0;
        refresh   = 1'b0;
        for (int i = 0; i < 32; i++) tb_buf[i] = 8'h20;
        repeat (3) @(negedge clk);
        checks++;
        if ({lcd_valid, lcd_rs, lcd_byte, init_done, busy} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b rs=%b b=%h id=%b busy=%b, want 0 0 00 0 1",
                     lcd_valid, lcd_rs, lcd_byte, init_done, busy);
        end
        rst = 1'b1;
    endtask

    task automatic test_init;
        logic [7:0] cmds [4];
        cmds[0] = 8'h28; cmds[1] = 8'h0C; cmds[2] = 8'h06; cmds[3] = 8'h01;
        for (int i = 0; i < 4; i++) begin
            get_xfer(x_rs, x_b, x_gap);
            checks++;
            if ({x_rs, x_b} !== {1'b0, cmds[i]}) begin
                errors++;
                $display("FAIL init_cmd%0d: got rs=%b b=%h, want rs=0 b=%h", i, x_rs, x_b, cmds[i]);
            end
            if (i > 0) begin
                checks++;
                if (x_gap < CMD_WAIT) begin
                    errors++;
                    $display("FAIL init_gap%0d: got %0d, want >= %0d", i, x_gap, CMD_WAIT);
                end
            end
        end
        for (int ln = 0; ln < 2; ln++) begin
            get_xfer(x_rs, x_b, x_gap);
            checks++;
            if ({x_rs, x_b} !== {1'b0, (ln == 0) ? 8'h80 : 8'hC0}) begin
                errors++;
                $display("FAIL init_addr_line%0d: got rs=%b b=%h", ln, x_rs, x_b);
            end
            if (ln == 0) begin
                checks++;
                if (x_gap < CLEAR_WAIT) begin
                    errors++;
                    $display("FAIL clear_gap: got %0d, want >= %0d", x_gap, CLEAR_WAIT);
                end
                checks++;
                if (init_done !== 1'b1) begin
                    errors++;
                    $display("FAIL init_done: got %b, want 1", init_done);
                end
            end
            for (int c = 0; c < 16; c++) begin
                get_xfer(x_rs, x_b, x_gap);
                checks++;
                if ({x_rs, x_b} !== {1'b1, 8'h20}) begin
                    errors++;
                    $display("FAIL init_line%0d_col%0d: got rs=%b b=%h, want rs=1 b=20", ln, c, x_rs, x_b);
                end
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: got %b, want 0", busy);
        end
    endtask

    task automatic test_write_line1;
        int seen;
        do_write(5'h13, 8'h41);
        get_xfer(x_rs, x_b, x_gap);
        checks++;
        if ({x_rs, x_b} !== {1'b0, 8'hC0}) begin
            errors++;
            $display("FAIL wr1_addr: got rs=%b b=%h, want rs=0 b=c0", x_rs, x_b);
        end
        for (int c = 0; c < 16; c++) begin
            get_xfer(x_rs, x_b, x_gap);
            checks++;
            if ({x_rs, x_b} !== {1'b1, (c == 3) ? 8'h41 : 8'h20}) begin
                errors++;
                $display("FAIL wr1_col%0d: got rs=%b b=%h", c, x_rs, x_b);
            end
        end
        seen = 0;
        repeat (20) begin
            if (lcd_valid) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wr1_no_line0: got %0d valid cycles busy=%b, want 0 and 0", seen, busy);
        end
    endtask

    task automatic test_stall;
        int         n;
        int         bad;
        logic [7:0] held;
        lcd_ready = 1'b0;
        do_write(5'h00, 8'h42);
        n = 0;
        while (!lcd_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        held = lcd_byte;
        checks++;
        if ({lcd_valid, lcd_rs, held} !== {1'b1, 1'b0, 8'h80}) begin
            errors++;
            $display("FAIL stall_offer: got v=%b rs=%b b=%h, want 1 0 80", lcd_valid, lcd_rs, held);
        end
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (!lcd_valid || lcd_rs || lcd_byte !== held) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL stall_hold: got %0d unstable cycles, want 0", bad);
        end
        lcd_ready = 1'b1;
        get_xfer(x_rs, x_b, x_gap);
        checks++;
        if ({x_rs, x_b} !== {1'b0, 8'h80} || x_gap !== 0) begin
            errors++;
            $display("FAIL stall_xfer: got rs=%b b=%h gap=%0d, want rs=0 b=80 gap=0", x_rs, x_b, x_gap);
        end
        checks++;
        if (lcd_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_valid_drop: got %b, want 0", lcd_valid);
        end
        for (int c = 0; c < 16; c++) begin
            get_xfer(x_rs, x_b, x_gap);
            checks++;
            if ({x_rs, x_b} !== {1'b1, tb_buf[c]}) begin
                errors++;
                $display("FAIL stall_col%0d: got rs=%b b=%h, want rs=1 b=%h", c, x_rs, x_b, tb_buf[c]);
            end
        end
    endtask

    task automatic test_round_robin;
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        for (int k = 0; k < 2; k++) begin
            int ln;
            ln = (k == 0) ? 1 : 0;
            get_xfer(x_rs, x_b, x_gap);
            checks++;
            if ({x_rs, x_b} !== {1'b0, (ln == 1) ? 8'hC0 : 8'h80}) begin
                errors++;
                $display("FAIL rr_order%0d: got rs=%b b=%h", k, x_rs, x_b);
            end
            for (int c = 0; c < 16; c++) begin
                get_xfer(x_rs, x_b, x_gap);
                checks++;
                if ({x_rs, x_b} !== {1'b1, tb_buf[ln*16+c]}) begin
                    errors++;
                    $display("FAIL rr_line%0d_col%0d: got rs=%b b=%h, want b=%h", ln, c, x_rs, x_b, tb_buf[ln*16+c]);
                end
            end
        end
    endtask

    task automatic test_rewrite_in_flight;
        do_write(5'h01, 8'h43);
        for (int pass = 0; pass < 2; pass++) begin
            get_xfer(x_rs, x_b, x_gap);
            checks++;
            if ({x_rs, x_b} !== {1'b0, 8'h80}) begin
                errors++;
                $display("FAIL rew_addr_pass%0d: got rs=%b b=%h, want rs=0 b=80", pass, x_rs, x_b);
            end
            for (int c = 0; c < 16; c++) begin
                if (pass == 0 && c == 3) begin
                    lcd_ready = 1'b0;
                    do_write(5'h0A, 8'h5A);
                    lcd_ready = 1'b1;
                end
                get_xfer(x_rs, x_b, x_gap);
                checks++;
                if ({x_rs, x_b} !== {1'b1, tb_buf[c]}) begin
                    errors++;
                    $display("FAIL rew_pass%0d_col%0d: got rs=%b b=%h, want b=%h", pass, c, x_rs, x_b, tb_buf[c]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        do_write(5'h1F, 8'h51);
        get_xfer(x_rs, x_b, x_gap);
        checks++;
        if ({x_rs, x_b} !== {1'b0, 8'hC0}) begin
            errors++;
            $display("FAIL rmid_addr: got rs=%b b=%h, want rs=0 b=c0", x_rs, x_b);
        end
        for (int c = 0; c < 7; c++) get_xfer(x_rs, x_b, x_gap);
        @(negedge clk);
        checks++;
        if ({lcd_valid, lcd_rs, lcd_byte} !== {1'b1, 1'b1, tb_buf[16+7]}) begin
            errors++;
            $display("FAIL rmid_col7_offer: got v=%b rs=%b b=%h, want 1 1 %h", lcd_valid, lcd_rs, lcd_byte, tb_buf[23]);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({lcd_valid, init_done, busy} !== {1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rmid_reset: got v=%b id=%b busy=%b, want 0 0 1", lcd_valid, init_done, busy);
        end
        rst = 1'b1;
        get_xfer(x_rs, x_b, x_gap);
        checks++;
        if ({x_rs, x_b} !== {1'b0, 8'h28}) begin
            errors++;
            $display("FAIL rmid_restart: got rs=%b b=%h, want rs=0 b=28", x_rs, x_b);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_write_line1();
        test_stall();
        test_round_robin();
        test_rewrite_in_flight();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
